wrf_loopback_sf: RTL and testbench
==================================

Name: wrf_loopback_sf

Overview:
- Parametrised store-and-forward successor to the White Rabbit fabric loopback.
- Accepts complete WR-fabric frames on a pipelined Wishbone sink and buffers them in a packet FIFO.
- Optionally overwrites the destination MAC, then replays each frame on a pipelined Wishbone source.
- Sits between the FEC encoder source and the FEC decoder sink in the FEC bench and in system loopback builds; adds overflow drop, source-error abort and frame counters.

Parameters:
- g_data_width, 16, fabric data width; only 16 or 32 are legal. Sel width is g_data_width/8.
- g_fifo_depth, 1024, data FIFO depth in words; power of two.
- g_frame_slots, 8, maximum number of committed frames held; power of two.
- g_max_words, 1024, frame word limit; a longer frame is dropped.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  reset; synchronous, active-high
- snk_cyc_i/snk_stb_i/snk_we_i  in  1  fabric sink control
- snk_sel_i  in  g_data_width/8  byte select
- snk_adr_i  in  2  fabric address: 0 data, 1 OOB, 2 status, 3 user
- snk_dat_i  in  g_data_width  sink data
- snk_ack_o/snk_stall_o/snk_err_o  out  1  sink handshake
- src_cyc_o/src_stb_o/src_we_o  out  1  fabric source control
- src_sel_o  out  g_data_width/8  byte select
- src_adr_o  out  2  source address
- src_dat_o  out  g_data_width  source data
- src_ack_i/src_stall_i/src_err_i  in  1  source handshake
- cfg_en_i  in  1  forwarding enable
- cfg_force_dmac_i  in  1  overwrite destination MAC
- cfg_dmac_i  in  48  replacement destination MAC, big-endian
- cfg_clr_i  in  1  synchronous counter clear
- rcv_cnt_o/drp_cnt_o/fwd_cnt_o/abt_cnt_o  out  32 each  frame counters

Behaviour:
- Reset values: all *_o are 0. FIFO pointers, frame slots and counters are cleared. A frame in flight on either side is discarded without being counted.
- Sink handshake:
  - snk_stall_o is always 0; snk_err_o is always 0.
  - snk_ack_o is asserted exactly one cycle after each accepted cycle with cyc&stb&we.
- Frame boundaries:
  - A frame starts on cyc 0→1 and ends on cyc 1→0.
  - Each word is stored in the FIFO as {adr, sel, dat}.
  - The write pointer advances speculatively. The frame start pointer is saved at cyc rise.
- Commit (cyc fall), in priority order:
  - rcv_cnt +1 for every frame.
  - The frame is dropped (write pointer restored, drp_cnt +1) if cfg_en_i=0 sampled at cyc rise, the FIFO was full on any word, all frame slots were occupied at cyc rise, the word count exceeded g_max_words, or the frame had zero words.
  - Otherwise the word count is pushed to the length FIFO.
  - A write on the same cycle as the FIFO becoming full sets the drop flag; that word is not stored.
- Source FSM:
  - IDLE: when the length FIFO is non-empty, pop the length L and go to BURST. src_cyc_o rises 1 cycle after the pop.
  - BURST: src_stb_o=1 with the FIFO head. The read pointer advances on cycles with stb&!stall. After L issued words go to DRAIN.
  - DRAIN: src_cyc_o=1 and src_stb_o=0 until acks equal L, then go to GAP and fwd_cnt +1.
  - GAP: exactly 1 cycle with cyc=0, then IDLE. Back-to-back frames are therefore separated by at least 1 idle cycle.
  - src_err_i in BURST or DRAIN: advance the read pointer to the frame end, deassert cyc next cycle, abt_cnt +1, go to GAP. No fwd_cnt increment.
- DMAC override:
  - Applies when cfg_force_dmac_i is sampled at frame pop.
  - The first 48/g_data_width words with adr=0 get dat replaced by cfg_dmac_i, MSB-first: 16-bit words 47:32, 31:16, 15:0; 32-bit words 47:16, then {15:0, original low half}.
  - Words with other adr values are never modified.
- Counters: wrap modulo 2^32. cfg_clr_i zeroes all counters and has priority over a simultaneous increment.
- Occupancy: a simultaneous write and read are legal. Occupancy = wr_ptr−rd_ptr modulo 2·g_fifo_depth; full is defined as occupancy = g_fifo_depth.
- Latency: the first source word appears no earlier than 2 cycles after the sink cyc fall of that frame.

Test Plan:
- Reset, then cfg_en=1, force=0; send a 16-bit frame of 256 words (dat=i, adr=0) → identical 256 words on src, fwd_cnt=1, rcv_cnt=1, drp_cnt=0.
- force=1, dmac=0x112233445566; send a frame starting with an OOB word then FFFF×3 data words → OOB word unchanged, next 3 data words 1122, 3344, 5566.
- g_fifo_depth=64; send a 100-word frame, then a 10-word frame → first frame dropped (drp=1), second forwarded intact; pointers end equal.
- src_stall_i random 50% and 8 frames back-to-back with src held stalled → all 8 forwarded in order; a 9th frame sent while 8 are still buffered is dropped (slots full).
- src_err_i pulsed at word 5 of a 20-word frame, then a second 20-word frame → abt_cnt=1, the second frame forwarded complete from its first word.
- rst_i asserted for 1 cycle mid-BURST → src_cyc_o=0 next cycle, all counters 0, a subsequent frame forwarded normally.

Source files
------------

// File: rtl/wrf_loopback_sf_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wrf_loopback_sf_if                                           |
// | Description : Pipelined Wishbone WR-fabric bus bundle (master/slave views)  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface wrf_loopback_sf_if #(
    parameter int g_data_width = 16
);
    logic                        cyc;
    logic                        stb;
    logic                        we;
    logic [g_data_width/8-1:0]   sel;
    logic [1:0]                  adr;
    logic [g_data_width-1:0]     dat;
    logic                        ack;
    logic                        stall;
    logic                        err;

    modport master (
        output cyc, stb, we, sel, adr, dat,
        input  ack, stall, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat,
        output ack, stall, err
    );
endinterface
`default_nettype wire

// File: rtl/wrf_loopback_sf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wrf_loopback_sf                                              |
// | Description : Store-and-forward WR-fabric loopback with DMAC override,     |
// |               overflow drop, source-error abort and frame counters        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wrf_loopback_sf #(
    parameter int g_data_width  = 16,
    parameter int g_fifo_depth  = 1024,
    parameter int g_frame_slots = 8,
    parameter int g_max_words   = 1024
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    wrf_loopback_sf_if.slave  snk,
    wrf_loopback_sf_if.master src,
    input  wire logic        cfg_en_i,
    input  wire logic        cfg_force_dmac_i,
    input  wire logic [47:0] cfg_dmac_i,
    input  wire logic        cfg_clr_i,
    output logic [31:0]      rcv_cnt_o,
    output logic [31:0]      drp_cnt_o,
    output logic [31:0]      fwd_cnt_o,
    output logic [31:0]      abt_cnt_o
);

    localparam int c_sel_w = g_data_width / 8;
    localparam int c_aw    = $clog2(g_fifo_depth);
    localparam int c_sw    = $clog2(g_frame_slots);
    localparam int c_lw    = $clog2(g_max_words + 1);
    localparam int c_ent_w = 2 + c_sel_w + g_data_width;

    localparam logic [c_aw:0]   c_depth    = (c_aw + 1)'(g_fifo_depth);
    localparam logic [c_sw:0]   c_slots    = (c_sw + 1)'(g_frame_slots);
    localparam logic [c_lw-1:0] c_max      = c_lw'(g_max_words);
    localparam logic [1:0]      c_dmac_wds = (g_data_width == 16) ? 2'd3 : 2'd2;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_burst = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_gap   = 2'd3;

    // Storage
    logic [c_ent_w-1:0] r_data_mem [g_fifo_depth];
    logic [c_lw-1:0]    r_len_mem  [g_frame_slots];

    // Sink side
    logic            r_cyc_d;
    logic            r_in_frame;
    logic            r_drop;
    logic            r_too_long;
    logic            r_ack;
    logic [c_lw-1:0] r_wcnt;
    logic [c_aw:0]   r_wr_ptr;
    logic [c_aw:0]   r_start_ptr;
    logic [c_sw:0]   r_len_wr;

    // Source side
    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [c_aw:0]   r_rd_ptr;
    logic [c_aw:0]   r_end_ptr;
    logic [c_sw:0]   r_len_rd;
    logic [c_lw-1:0] r_len;
    logic [c_lw-1:0] r_issued;
    logic [c_lw-1:0] r_acked;
    logic            r_force;
    logic [1:0]      r_dmac_idx;

    logic [31:0] r_rcv_cnt, r_drp_cnt, r_fwd_cnt, r_abt_cnt;

    logic            w_rise, w_fall, w_word, w_active, w_store, w_commit_ok;
    logic            w_full, w_in_flight, w_slots_full, w_drop_cur, w_long_cur;
    logic [c_aw:0]   w_occ;
    logic [c_sw:0]   w_len_cnt, w_slots_used;
    logic [c_lw-1:0] w_cnt_cur;

    logic                    w_len_empty, w_pop, w_xfer, w_abort, w_last_issue, w_done;
    logic [c_lw-1:0]         w_issued_nxt, w_acked_nxt, w_len_head;
    logic [c_ent_w-1:0]      w_head;
    logic [1:0]              w_head_adr;
    logic [c_sel_w-1:0]      w_head_sel;
    logic [g_data_width-1:0] w_head_dat;
    logic [g_data_width-1:0] w_dmac_dat;
    logic                    w_dmac_hit;
    logic [g_data_width-1:0] w_out_dat;

    // ------------------------------------------------------------------
    // Sink: frame framing, speculative write, commit/drop at cyc fall
    // ------------------------------------------------------------------
    assign w_rise   = snk.cyc & ~r_cyc_d;
    assign w_fall   = ~snk.cyc & r_cyc_d & r_in_frame;
    assign w_word   = snk.cyc & snk.stb & snk.we;
    assign w_active = snk.cyc & (w_rise | r_in_frame);

    assign w_occ        = r_wr_ptr - r_rd_ptr;
    assign w_full       = (w_occ == c_depth);
    assign w_in_flight  = (r_state == c_st_burst) | (r_state == c_st_drain);
    assign w_len_cnt    = r_len_wr - r_len_rd;
    assign w_slots_used = w_len_cnt + {{c_sw{1'b0}}, w_in_flight};
    assign w_slots_full = (w_slots_used >= c_slots);

    // The rise cycle may already carry a word, so frame state is taken
    // from the rise-time values instead of last frame's leftovers.
    assign w_drop_cur = w_rise ? (~cfg_en_i | w_slots_full) : r_drop;
    assign w_long_cur = w_rise ? 1'b0 : r_too_long;
    assign w_cnt_cur  = w_rise ? '0 : r_wcnt;

    assign w_store     = w_word & w_active & ~w_drop_cur & ~w_full;
    assign w_commit_ok = ~r_drop & ~r_too_long & (r_wcnt != '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // Tracking cyc through reset keeps a frame already in flight
            // from looking like a fresh start once reset is released.
            r_cyc_d     <= snk.cyc;
            r_in_frame  <= 1'b0;
            r_drop      <= 1'b0;
            r_too_long  <= 1'b0;
            r_ack       <= 1'b0;
            r_wcnt      <= '0;
            r_wr_ptr    <= '0;
            r_start_ptr <= '0;
            r_len_wr    <= '0;
        end else begin
            r_cyc_d <= snk.cyc;
            r_ack   <= w_word;
            if (w_rise) begin
                r_in_frame  <= 1'b1;
                r_start_ptr <= r_wr_ptr;
            end
            if (w_active) begin
                r_drop     <= w_drop_cur | (w_word & w_full);
                r_too_long <= w_long_cur | (w_word & (w_cnt_cur == c_max));
                if (w_word && (w_cnt_cur != c_max)) begin
                    r_wcnt <= w_cnt_cur + c_lw'(1);
                end else begin
                    r_wcnt <= w_cnt_cur;
                end
            end
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + (c_aw + 1)'(1);
            end
            if (w_fall) begin
                r_in_frame <= 1'b0;
                if (w_commit_ok) begin
                    r_len_wr <= r_len_wr + (c_sw + 1)'(1);
                end else begin
                    r_wr_ptr <= r_start_ptr;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_store) begin
            r_data_mem[r_wr_ptr[c_aw-1:0]] <= {snk.adr, snk.sel, snk.dat};
        end
        if (w_fall && w_commit_ok) begin
            r_len_mem[r_len_wr[c_sw-1:0]] <= r_wcnt;
        end
    end

    assign snk.ack   = r_ack;
    assign snk.stall = 1'b0;
    assign snk.err   = 1'b0;

    // ------------------------------------------------------------------
    // Source: replay FSM
    // ------------------------------------------------------------------
    assign w_len_empty  = (r_len_wr == r_len_rd);
    assign w_len_head   = r_len_mem[r_len_rd[c_sw-1:0]];
    assign w_pop        = (r_state == c_st_idle) & ~w_len_empty;
    assign w_abort      = w_in_flight & src.err;
    assign w_xfer       = (r_state == c_st_burst) & ~src.stall & ~src.err;
    assign w_issued_nxt = r_issued + c_lw'(1);
    assign w_acked_nxt  = r_acked + {{(c_lw - 1){1'b0}}, src.ack};
    assign w_last_issue = w_xfer & (w_issued_nxt == r_len);
    assign w_done       = (r_state == c_st_drain) & ~src.err & (w_acked_nxt == r_len);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_pop) begin
                    w_next = c_st_burst;
                end
            end
            c_st_burst: begin
                if (src.err) begin
                    w_next = c_st_gap;
                end else if (w_last_issue) begin
                    w_next = c_st_drain;
                end
            end
            c_st_drain: begin
                if (src.err || w_done) begin
                    w_next = c_st_gap;
                end
            end
            default: w_next = c_st_idle;
        endcase
    end

    always_comb begin
        src.cyc = w_in_flight;
        src.we  = w_in_flight;
        src.stb = (r_state == c_st_burst);
        src.sel = '0;
        src.adr = '0;
        src.dat = '0;
        if (r_state == c_st_burst) begin
            src.sel = w_head_sel;
            src.adr = w_head_adr;
            src.dat = w_out_dat;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr   <= '0;
            r_end_ptr  <= '0;
            r_len_rd   <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_acked    <= '0;
            r_force    <= 1'b0;
            r_dmac_idx <= '0;
        end else begin
            if (w_pop) begin
                r_len      <= w_len_head;
                r_end_ptr  <= r_rd_ptr + (c_aw + 1)'(w_len_head);
                r_len_rd   <= r_len_rd + (c_sw + 1)'(1);
                r_issued   <= '0;
                r_acked    <= '0;
                r_force    <= cfg_force_dmac_i;
                r_dmac_idx <= '0;
            end
            if (w_abort) begin
                r_rd_ptr <= r_end_ptr;
            end else if (w_xfer) begin
                r_rd_ptr <= r_rd_ptr + (c_aw + 1)'(1);
                r_issued <= w_issued_nxt;
                if ((w_head_adr == 2'd0) && (r_dmac_idx != c_dmac_wds)) begin
                    r_dmac_idx <= r_dmac_idx + 2'd1;
                end
            end
            if (w_in_flight && src.ack) begin
                r_acked <= w_acked_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Head word and destination MAC override
    // ------------------------------------------------------------------
    assign w_head     = r_data_mem[r_rd_ptr[c_aw-1:0]];
    assign w_head_adr = w_head[c_ent_w-1 -: 2];
    assign w_head_sel = w_head[g_data_width +: c_sel_w];
    assign w_head_dat = w_head[g_data_width-1:0];
    assign w_dmac_hit = r_force & (w_head_adr == 2'd0) & (r_dmac_idx != c_dmac_wds);
    assign w_out_dat  = w_dmac_hit ? w_dmac_dat : w_head_dat;

    generate
        if (g_data_width == 16) begin : g_dmac16
            always_comb begin
                case (r_dmac_idx)
                    2'd0:    w_dmac_dat = cfg_dmac_i[47:32];
                    2'd1:    w_dmac_dat = cfg_dmac_i[31:16];
                    default: w_dmac_dat = cfg_dmac_i[15:0];
                endcase
            end
        end else begin : g_dmac32
            // Second word carries only the low MAC half; its low half is payload.
            always_comb begin
                if (r_dmac_idx == 2'd0) begin
                    w_dmac_dat = cfg_dmac_i[47:16];
                end else begin
                    w_dmac_dat = {cfg_dmac_i[15:0], w_head_dat[15:0]};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Frame counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || cfg_clr_i) begin
            r_rcv_cnt <= '0;
            r_drp_cnt <= '0;
            r_fwd_cnt <= '0;
            r_abt_cnt <= '0;
        end else begin
            if (w_fall) begin
                r_rcv_cnt <= r_rcv_cnt + 32'd1;
            end
            if (w_fall && !w_commit_ok) begin
                r_drp_cnt <= r_drp_cnt + 32'd1;
            end
            if (w_done) begin
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            end
            if (w_abort) begin
                r_abt_cnt <= r_abt_cnt + 32'd1;
            end
        end
    end

    assign rcv_cnt_o = r_rcv_cnt;
    assign drp_cnt_o = r_drp_cnt;
    assign fwd_cnt_o = r_fwd_cnt;
    assign abt_cnt_o = r_abt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wrf_loopback_sf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wrf_loopback_sf                                           |
// | Description : Scoreboard bench for wrf_loopback_sf (16-bit, 64-word FIFO)   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wrf_loopback_sf;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wrf_loopback_sf_if #(.g_data_width(DW)) snk_if ();
    wrf_loopback_sf_if #(.g_data_width(DW)) src_if ();

    logic        cfg_en, cfg_force, cfg_clr;
    logic [47:0] cfg_dmac;
    logic [31:0] rcv_cnt, drp_cnt, fwd_cnt, abt_cnt;

    wrf_loopback_sf #(
        .g_data_width (DW),
        .g_fifo_depth (64),
        .g_frame_slots(8),
        .g_max_words  (48)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .snk             (snk_if),
        .src             (src_if),
        .cfg_en_i        (cfg_en),
        .cfg_force_dmac_i(cfg_force),
        .cfg_dmac_i      (cfg_dmac),
        .cfg_clr_i       (cfg_clr),
        .rcv_cnt_o       (rcv_cnt),
        .drp_cnt_o       (drp_cnt),
        .fwd_cnt_o       (fwd_cnt),
        .abt_cnt_o       (abt_cnt)
    );

    int checks = 0;
    int errors = 0;
    int e_rcv = 0, e_drp = 0, e_fwd = 0, e_abt = 0;
    int stall_mode = 0;
    int mon_words = 0;
    logic [19:0] exp_q [$];
    logic [1:0]  f_adr [$];
    logic [15:0] f_dat [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every accepted source word is popped and compared
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (rst || !src_if.cyc) begin
                mon_words = 0;
            end else if (src_if.stb && !src_if.stall && !src_if.err) begin
                if (exp_q.size() == 0) begin
                    check("src_extra_word", {12'h0, src_if.adr, src_if.sel, src_if.dat}, 32'hffffffff);
                end else begin
                    e = exp_q.pop_front();
                    check("src_word", {12'h0, src_if.adr, src_if.sel, src_if.dat}, {12'h0, e});
                end
                mon_words++;
            end
        end
    end

    // Source responder: ack one cycle after each accepted word
    initial begin
        logic pend;
        src_if.ack = 1'b0;
        forever begin
            @(negedge clk);
            pend = src_if.cyc & src_if.stb & ~src_if.stall & ~src_if.err;
            @(posedge clk);
            #1 src_if.ack = pend;
        end
    end

    initial begin
        src_if.stall = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode == 1)      src_if.stall = 1'b1;
            else if (stall_mode == 2) src_if.stall = 1'($urandom_range(0, 1));
            else                      src_if.stall = 1'b0;
        end
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic mk_seq(input int n, input logic [15:0] base);
        f_adr.delete();
        f_dat.delete();
        for (int i = 0; i < n; i++) begin
            f_adr.push_back(2'd0);
            f_dat.push_back(base + 16'(i));
        end
    endtask

    task automatic send_frame(input bit fwd);
        int acks = 0;
        int n = f_dat.size();
        @(posedge clk);
        #1;
        snk_if.cyc = 1'b1;
        if (n == 0) begin
            snk_if.stb = 1'b0;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < n; i++) begin
            snk_if.stb = 1'b1;
            snk_if.adr = f_adr[i];
            snk_if.dat = f_dat[i];
            if (fwd) exp_q.push_back({f_adr[i], 2'b11, f_dat[i]});
            @(posedge clk);
            #1;
            acks += int'(snk_if.ack);
        end
        snk_if.cyc = 1'b0;
        snk_if.stb = 1'b0;
        @(posedge clk);
        #1;
        acks += int'(snk_if.ack);
        check("snk_ack_count", acks, n);
        e_rcv++;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || src_if.cyc) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check(name, (exp_q.size() == 0 && !src_if.cyc), 1);
    endtask

    task automatic check_cnt();
        @(negedge clk);
        check("rcv_cnt", rcv_cnt, e_rcv);
        check("drp_cnt", drp_cnt, e_drp);
        check("fwd_cnt", fwd_cnt, e_fwd);
        check("abt_cnt", abt_cnt, e_abt);
    endtask

    task automatic inject_err(input int at_word);
        int t = 0;
        while (!(src_if.stb && mon_words == at_word) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("err_point_reached", (t < 2000), 1);
        src_if.err = 1'b1;
        @(posedge clk);
        #1 src_if.err = 1'b0;
    endtask

    initial begin
        int t;
        snk_if.cyc = 1'b0; snk_if.stb = 1'b0; snk_if.we = 1'b1;
        snk_if.sel = 2'b11; snk_if.adr = 2'd0; snk_if.dat = '0;
        src_if.err = 1'b0;
        cfg_en = 1'b1; cfg_force = 1'b0; cfg_clr = 1'b0; cfg_dmac = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_src_cyc", src_if.cyc, 0);
        check("rst_src_stb", src_if.stb, 0);
        check("rst_src_dat", src_if.dat, 0);
        check("rst_snk_ack", snk_if.ack, 0);
        check("snk_stall_err", {snk_if.stall, snk_if.err}, 0);
        check_cnt();

        // Frame of exactly g_max_words words passes unchanged
        mk_seq(48, 16'h0000);
        send_frame(1); e_fwd++;
        wait_drain("drain_max_len");
        check_cnt();

        // One word over the limit is dropped
        mk_seq(49, 16'h0100);
        send_frame(0); e_drp++;
        wait_drain("drain_too_long");
        check_cnt();

        // FIFO overflow: A fills 40, B (30) overflows and drops, C (20) fits
        stall_mode = 1;
        mk_seq(40, 16'h0200); send_frame(1); e_fwd++;
        mk_seq(30, 16'h0300); send_frame(0); e_drp++;
        mk_seq(20, 16'h0400); send_frame(1); e_fwd++;
        stall_mode = 2;
        wait_drain("drain_overflow");
        check_cnt();

        // DMAC override: OOB word untouched, first 3 data words replaced
        stall_mode = 0;
        cfg_force = 1'b1;
        cfg_dmac  = 48'h112233445566;
        f_adr = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
        f_dat = '{16'hABCD, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7777};
        exp_q.push_back({2'd1, 2'b11, 16'hABCD});
        exp_q.push_back({2'd0, 2'b11, 16'h1122});
        exp_q.push_back({2'd0, 2'b11, 16'h3344});
        exp_q.push_back({2'd0, 2'b11, 16'h5566});
        exp_q.push_back({2'd0, 2'b11, 16'h7777});
        send_frame(0); e_fwd++;
        wait_drain("drain_dmac");
        cfg_force = 1'b0;
        check_cnt();

        // Slot limit: 8 frames buffered behind a stalled source, 9th dropped
        stall_mode = 1;
        for (int k = 0; k < 8; k++) begin
            mk_seq(4, 16'h0500 + 16'(16 * k));
            send_frame(1); e_fwd++;
        end
        mk_seq(4, 16'h05F0);
        send_frame(0); e_drp++;
        stall_mode = 2;
        wait_drain("drain_slots");
        check_cnt();

        // Zero-word frame and disabled forwarding both drop
        stall_mode = 0;
        f_adr.delete(); f_dat.delete();
        send_frame(0); e_drp++;
        cfg_en = 1'b0;
        mk_seq(5, 16'h0580);
        send_frame(0); e_drp++;
        cfg_en = 1'b1;
        wait_drain("drain_drops");
        check_cnt();

        // Source error at word 5 aborts; the next frame goes out complete
        fork
            inject_err(5);
        join_none
        mk_seq(20, 16'h0600);
        for (int i = 0; i < 5; i++) exp_q.push_back({2'd0, 2'b11, 16'h0600 + 16'(i)});
        send_frame(0); e_abt++;
        mk_seq(20, 16'h0700);
        send_frame(1); e_fwd++;
        wait_drain("drain_abort");
        check_cnt();

        // Counter clear
        @(posedge clk); #1 cfg_clr = 1'b1;
        @(posedge clk); #1 cfg_clr = 1'b0;
        e_rcv = 0; e_drp = 0; e_fwd = 0; e_abt = 0;
        check_cnt();

        // Reset in the middle of a burst
        mk_seq(40, 16'h0800);
        send_frame(1);
        t = 0;
        while (!(src_if.stb && mon_words >= 10) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("rst_point_reached", (t < 2000), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        e_rcv = 0; e_drp = 0; e_fwd = 0; e_abt = 0;
        @(negedge clk);
        check("rst_mid_src_cyc", src_if.cyc, 0);
        check_cnt();
        mk_seq(6, 16'h0900);
        send_frame(1); e_fwd++;
        wait_drain("drain_after_rst");
        check_cnt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
